// File: rtl/text_cmd_engine.sv
// text_cmd_engine: byte-stream command decoder driving the character RAM write port.
// Tracks a (col,row) cursor and decodes the LF/CR/BS/clear/positioning codes.
// Optional hardware scrolling through a row-offset register is built when the
// TEXT_SCROLL_EN macro is defined. Without it, row advance at the bottom wraps to 0.
module text_cmd_engine #(
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 32,
  parameter int unsigned ADDR_W    = 11,
  parameter logic [7:0]  FILL_CHAR = 8'h00,
  localparam int unsigned COL_W    = 6,
  localparam int unsigned ROW_W    = 6
) (
  input  logic              in_main_clock,
  input  logic              in_reset,
  input  logic [7:0]        in_byte,
  input  logic              in_byte_valid,
  output logic              out_byte_ready,
  output logic [ADDR_W-1:0] out_ram_addr,
  output logic [7:0]        out_ram_data,
  output logic              out_ram_we,
  output logic [COL_W-1:0]  out_cursor_col,
  output logic [ROW_W-1:0]  out_cursor_row,
  output logic [ROW_W-1:0]  out_row_offset,
  output logic              out_busy
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ROWS * COLS - 1);
  localparam logic [COL_W-1:0]  LastCol  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LastRow  = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle, StDecode, StWrite, StAdvance, StClearRow, StClearAll
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        byte_q, byte_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  // Row-advance result for the current cursor
  logic [ROW_W-1:0]  adv_row;

`ifdef TEXT_SCROLL_EN
  logic [ROW_W-1:0]  off_d;
  logic              scroll_q, scroll_d;
  logic [COL_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ROW_W-1:0]  adv_off;
  logic              adv_scroll;
`else
  assign off_q = '0;
`endif

  logic is_lf, is_cr, is_bs, is_clr, is_col, is_row, is_print;
  logic [COL_W:0] col_inc;
  logic           col_wrap;

  assign is_lf    = (byte_q == 8'h0A);
  assign is_cr    = (byte_q == 8'h0D);
  assign is_bs    = (byte_q == 8'h08);
  assign is_clr   = (byte_q == 8'hFF);
  assign is_col   = (byte_q[7:6] == 2'b10);
  assign is_row   = (byte_q[7:6] == 2'b11) && !is_clr;
  assign is_print = !(is_lf || is_cr || is_bs || is_clr || is_col || is_row);
  assign col_inc  = {1'b0, col_q} + 1'b1;
  assign col_wrap = (col_inc >= (COL_W + 1)'(COLS));

  // Physical RAM address of a logical cell, applying the row offset modulo ROWS
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [COL_W-1:0] c,
                                                  input logic [ROW_W-1:0] r,
                                                  input logic [ROW_W-1:0] o);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, o};
    if (s >= (ROW_W + 1)'(ROWS)) s = s - (ROW_W + 1)'(ROWS);
    return ADDR_W'(s) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // Row advance: step down, or at the bottom either scroll or wrap to the top
  always_comb begin
    adv_row = row_q;
`ifdef TEXT_SCROLL_EN
    adv_off    = off_q;
    adv_scroll = 1'b0;
`endif
    if (row_q < LastRow) begin
      adv_row = row_q + 1'b1;
    end else begin
`ifdef TEXT_SCROLL_EN
      adv_scroll = 1'b1;
      adv_off    = (off_q == LastRow) ? '0 : off_q + 1'b1;
`else
      adv_row = '0;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge in_main_clock or posedge in_reset) begin
    if (in_reset) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (in_byte_valid) state_d = StDecode;
      StDecode: begin
        if (is_clr)                                  state_d = StClearAll;
        else if (is_print || (is_bs && col_q != '0)) state_d = StWrite;
`ifdef TEXT_SCROLL_EN
        else if (is_lf && adv_scroll)                state_d = StClearRow;
`endif
        else                                         state_d = StIdle;
      end
      StWrite:  state_d = StAdvance;
`ifdef TEXT_SCROLL_EN
      StAdvance:  state_d = scroll_q ? StClearRow : StIdle;
      StClearRow: if (clr_cnt_q == LastCol) state_d = StIdle;
`else
      StAdvance:  state_d = StIdle;
`endif
      StClearAll: if (addr_q == LastAddr) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs: handshake and write strobe
  always_comb begin
    out_byte_ready = (state_q == StIdle);
    out_busy       = (state_q != StIdle);
    out_ram_we     = (state_q == StWrite) || (state_q == StClearRow) ||
                     (state_q == StClearAll);
  end

  // Datapath next-state: cursor, offset, RAM address/data
  always_comb begin
    byte_d = byte_q;
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    data_d = data_q;
`ifdef TEXT_SCROLL_EN
    off_d     = off_q;
    scroll_d  = scroll_q;
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      StIdle: if (in_byte_valid) byte_d = in_byte;
      StDecode: begin
        if (is_lf) begin
          col_d = '0;
          row_d = adv_row;
`ifdef TEXT_SCROLL_EN
          off_d     = adv_off;
          addr_d    = phys_addr('0, LastRow, adv_off);
          data_d    = FILL_CHAR;
          clr_cnt_d = '0;
`endif
        end else if (is_cr) begin
          col_d = '0;
        end else if (is_bs) begin
          if (col_q != '0) begin
            addr_d = phys_addr(col_q - 1'b1, row_q, off_q);
            data_d = 8'h20;
          end
        end else if (is_clr) begin
          col_d  = '0;
          row_d  = '0;
          addr_d = '0;
          data_d = FILL_CHAR;
`ifdef TEXT_SCROLL_EN
          off_d  = '0;
`endif
        end else if (is_col) begin
          col_d = ({1'b0, byte_q[5:0]} >= (COL_W + 1)'(COLS)) ? '0 : byte_q[5:0];
        end else if (is_row) begin
          row_d = ({1'b0, byte_q[5:0]} >= (ROW_W + 1)'(ROWS)) ? '0 : byte_q[5:0];
        end else begin
          addr_d = phys_addr(col_q, row_q, off_q);
          data_d = byte_q;
        end
      end
      StWrite: begin
`ifdef TEXT_SCROLL_EN
        scroll_d = 1'b0;
`endif
        if (is_bs) begin
          col_d = col_q - 1'b1;
        end else if (col_wrap) begin
          col_d = '0;
          row_d = adv_row;
`ifdef TEXT_SCROLL_EN
          off_d    = adv_off;
          scroll_d = adv_scroll;
`endif
        end else begin
          col_d = col_inc[COL_W-1:0];
        end
      end
`ifdef TEXT_SCROLL_EN
      StAdvance: begin
        // Offset already moved, so the new bottom logical row is the old top row
        if (scroll_q) begin
          addr_d    = phys_addr('0, LastRow, off_q);
          data_d    = FILL_CHAR;
          clr_cnt_d = '0;
        end
      end
      StClearRow: begin
        if (clr_cnt_q != LastCol) begin
          addr_d    = addr_q + 1'b1;
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`endif
      StClearAll: if (addr_q != LastAddr) addr_d = addr_q + 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge in_main_clock or posedge in_reset) begin
    if (in_reset) begin
      byte_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef TEXT_SCROLL_EN
      off_q     <= '0;
      scroll_q  <= 1'b0;
      clr_cnt_q <= '0;
`endif
    end else begin
      byte_q    <= byte_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef TEXT_SCROLL_EN
      off_q     <= off_d;
      scroll_q  <= scroll_d;
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  assign out_ram_addr   = addr_q;
  assign out_ram_data   = data_q;
  assign out_cursor_col = col_q;
  assign out_cursor_row = row_q;
  assign out_row_offset = off_q;

endmodule

// File: tb/tb_text_cmd_engine.sv
// Directed bench for text_cmd_engine with a write scoreboard (default parameters).
// Expectations for the bottom-row case follow TEXT_SCROLL_EN when it is defined.
module tb_text_cmd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        ready, we, busy;
  logic [10:0] addr;
  logic [7:0]  data;
  logic [5:0]  col, row, off;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  text_cmd_engine dut (
    .in_main_clock (clk),
    .in_reset      (rst),
    .in_byte       (in_byte),
    .in_byte_valid (in_valid),
    .out_byte_ready(ready),
    .out_ram_addr  (addr),
    .out_ram_data  (data),
    .out_ram_we    (we),
    .out_cursor_col(col),
    .out_cursor_row(row),
    .out_row_offset(off),
    .out_busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (chk_en && we) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_we: got addr %0d data %0d want no write", addr, data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("we_addr", 32'(addr), mon_e.addr);
        chk("we_data", 32'(data), mon_e.data);
        if (mon_e.cyc >= 0) chk("we_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Present a byte and hold it until accepted; acc = cycle index right after accept
  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 3000, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(output int rc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 3000);
    chk("idle_timeout", n < 3000, 1);
    rc = cyc;
  endtask

  task automatic push(input int a, input int d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  initial begin
    int acc, acc2, rc, n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    chk_en   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_off", off, 0);
    rst = 1'b0;

    // Printable write
    send(8'h41, acc);
    push(0, 8'h41, acc + 1);
    wait_idle(rc);
    chk("print_ready_lat", rc, acc + 3);
    chk("print_col", col, 1);
    chk("print_row", row, 0);

    // Bottom-right write
    send(8'hA7, acc);
    send(8'hDF, acc);
    send(8'h42, acc);
    push(1279, 8'h42, acc + 1);
`ifdef TEXT_SCROLL_EN
    for (int i = 0; i < 40; i++) push(i, 8'h00, acc + 3 + i);
    wait_idle(rc);
    chk("scroll_ready_lat", rc, acc + 43);
    chk("br_col", col, 0);
    chk("br_row", row, 31);
    chk("br_off", off, 1);
`else
    wait_idle(rc);
    chk("br_ready_lat", rc, acc + 3);
    chk("br_col", col, 0);
    chk("br_row", row, 0);
    chk("br_off", off, 0);
`endif
    send(8'h43, acc);
    push(0, 8'h43, acc + 1);
    wait_idle(rc);
    chk("after_br_col", col, 1);

    // Control codes
    send(8'h0D, acc);
    wait_idle(rc);
    chk("cr_col", col, 0);
    chk("cr_ready_lat", rc, acc + 1);
    send(8'h08, acc);
    wait_idle(rc);
    chk("bs0_col", col, 0);
    send(8'h85, acc);
    send(8'h08, acc);
    push(4, 8'h20, acc + 1);
    wait_idle(rc);
    chk("bs_col", col, 4);
    send(8'hAD, acc);
    wait_idle(rc);
    chk("colset_oob", col, 0);
    send(8'h85, acc);
    send(8'hC3, acc);
    send(8'h0A, acc);
    wait_idle(rc);
    chk("lf_col", col, 0);
    chk("lf_row", row, 4);
    send(8'hE5, acc);
    wait_idle(rc);
    chk("rowset_oob", row, 0);

    // Clear all
    send(8'h61, acc);
    push(0, 8'h61, acc + 1);
    send(8'hFF, acc);
    for (int i = 0; i < 1280; i++) push(i, 8'h00, acc + 1 + i);
    wait_idle(rc);
    chk("clr_ready_lat", rc, acc + 1281);
    chk("clr_col", col, 0);
    chk("clr_row", row, 0);
    chk("clr_off", off, 0);

    // Reset in the middle of a clear
    chk_en = 1'b0;
    send(8'hFF, acc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(we && addr == 11'd600) && n < 3000);
    chk("reach_600", n < 3000, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_col", col, 0);
    chk("mid_rst_off", off, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Byte held while busy is accepted exactly once
    send(8'h41, acc);
    push(0, 8'h41, acc + 1);
    send(8'h42, acc2);
    push(1, 8'h42, acc2 + 1);
    chk("hold_accept_cycle", acc2, acc + 4);
    wait_idle(rc);
    repeat (4) @(negedge clk);
    chk("hold_col", col, 2);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_cmd_engine.md
# text_cmd_engine

Parametrised byte-stream command engine that converts received bytes into character-RAM writes for the EL text display. It sits between the byte source (UART receiver or a later SPI receiver) and the write port of the character RAM. It tracks a cursor (column, row) and decodes positioning, clear and control codes. It also provides hardware scrolling through a row-offset register that the display read path applies.

## Interface
- COLS, 40, text columns per row (1..64)
- ROWS, 32, text rows (1..64)
- ADDR_W, 11, character RAM address width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- FILL_CHAR, 8'h00, byte written by clear-screen and scroll row-clear
- (local) COL_W = ROW_W = 6

- in_main_clock  in  1  system clock; everything runs on its rising edge
- in_reset  in  1  asynchronous, active-high reset
- in_byte  in  8  command/data byte
- in_byte_valid  in  1  in_byte is valid this cycle
- out_byte_ready  out  1  engine can accept a byte; reset 1
- out_ram_addr  out  ADDR_W  character RAM write address; reset 0
- out_ram_data  out  8  character RAM write data; reset 0
- out_ram_we  out  1  one-cycle write strobe per address; reset 0
- out_cursor_col  out  COL_W  current logical column; reset 0
- out_cursor_row  out  ROW_W  current logical row; reset 0
- out_row_offset  out  ROW_W  physical row that holds logical row 0; reset 0
- out_busy  out  1  equals ~out_byte_ready

## Operation
- A byte is accepted on the rising edge where in_byte_valid & out_byte_ready. out_byte_ready is 1 only in the IDLE state.
- Physical address = prow*COLS + col, with prow = row + offset, minus ROWS if the sum is ≥ ROWS.
- The engine decodes the accepted byte as follows:
  - 0x0A LF: col ← 0, then row advance.
  - 0x0D CR: col ← 0. No write.
  - 0x08 BS: if col > 0, col ← col-1 and write 0x20 at the new position. If col = 0, do nothing.
  - 0xFF: clear all.
  - 10cccccc: col ← c, or 0 if c ≥ COLS.
  - 11rrrrrr: row ← r, or 0 if r ≥ ROWS.
  - Any other byte is printable: write it at (col, row), then col+1. If the result is ≥ COLS, col ← 0 and row advance.
- Row advance: if row < ROWS-1, row+1. At ROWS-1 the behaviour depends on TEXT_SCROLL_EN (see Configuration).
- Clear all: writes FILL_CHAR to addresses 0..ROWS*COLS-1 in ascending order. Afterwards col, row and offset are all 0.
- States:
  - IDLE → DECODE on accept.
  - DECODE → WRITE (printable, or BS with col>0) | CLEAR_ALL | IDLE (all other codes).
  - WRITE → ADVANCE → IDLE, or → CLEAR_ROW if a scroll was triggered.
  - CLEAR_ROW → IDLE.
  - CLEAR_ALL → IDLE.

## Timing
- Accept in cycle k; DECODE in cycle k+1.
- Positioning and CR: IDLE in k+2.
- LF: the cursor update is visible in k+2, and the engine is IDLE in k+2 unless a scroll row-clear follows.
- Printable/BS: out_ram_we=1 in k+2 with stable address and data. Cursor updates in k+3 (ADVANCE). IDLE in k+4 if no scroll.
- CLEAR_ROW: COLS consecutive we cycles, address ascending across the new bottom physical row, then IDLE.
- CLEAR_ALL: we in cycles k+2 .. k+1+ROWS*COLS. IDLE in k+2+ROWS*COLS.
- out_ram_we is never high outside WRITE, CLEAR_ROW or CLEAR_ALL.
- Offset and cursor updates from a scroll become visible in the cycle after the triggering write or LF decode.
- Bytes presented while busy are not accepted. The source must hold valid and data until accepted.
- in_reset asserted at any time, including mid-clear: all outputs take their reset values immediately and the FSM returns to IDLE. RAM contents written so far are not restored.

## Configuration
- TEXT_SCROLL_EN defined: row advance at ROWS-1 keeps row = ROWS-1 and sets offset ← (offset+1) mod ROWS. CLEAR_ROW then fills the new bottom logical row with FILL_CHAR.
- TEXT_SCROLL_EN undefined: row advance at ROWS-1 sets row ← 0 without clearing. out_row_offset is tied to 0 and CLEAR_ROW is not built.

## Test plan
All scenarios use default parameters.
- Printable write: reset, send 0x41 → one we pulse with addr 0, data 0x41, exactly 2 cycles after accept. Cursor then (1,0); ready high 4 cycles after accept.
- Bottom-right write, scroll off: send 0xA7, 0xDF, 0x42 → we at addr 1279 with data 0x42, then cursor (0,0) and offset 0.
- Bottom-right write, scroll on: same stimulus → we at addr 1279, then 40 we cycles with addr 0..39 and data 0x00. Cursor (0,31), offset 1. A subsequent 0x43 writes addr 0.
- Clear: send 0xFF after arbitrary text → 1280 we cycles with addr 0..1279, data 0x00. Cursor (0,0), offset 0; ready 1282 cycles after accept.
- Control codes: BS at col 0 → no write; 0x85 then BS → we addr 4 data 0x20, cursor col 4; 0xAD (col 45) → col 0; CR → col 0 with no write.
- Reset mid-clear and busy hold: assert in_reset at clear address 600 → we drops immediately, and cursor, offset, ready and addr take reset values. A byte held valid while busy is accepted exactly once, when ready returns.
